gray_onehot_counter: RTL and testbench
======================================

Name: gray_onehot_counter

Overview:
- Parametrised modulo-MOD up/down counter.
- Each state is presented three ways:
  - binary position;
  - reflected Gray code;
  - one-hot position vector.
- Generalises the team's fixed 4-bit Gray→10-line one-hot decoder into a registered, loadable, bidirectional counter for any modulus.
- Used as a position/sequence generator for display and stepper-style datapaths.
- Also serves as the source of Gray codes that downstream decoders consume.

Parameters:
- MOD, 10, number of states (≥2); counts 0..MOD-1.
- REVERSE, 1, one-hot bit ordering:
  - 1: position k drives onehot[MOD-1-k], so position 0 is the MSB line.
  - 0: position k drives onehot[k].
- W (localparam), $clog2(MOD), width of the binary and Gray fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  in  1  synchronous load strobe.
- load_val  in  W  binary position to load.
- pos  out  W  current binary position, registered.
- gray  out  W  reflected Gray code of pos: pos ^ (pos>>1), registered.
- onehot  out  MOD  one-hot of pos per REVERSE, registered.
- wrap  out  1  one-cycle pulse when a count crossed the modulus boundary.
- load_err  out  1  one-cycle pulse when a load was rejected.

Behaviour:
- Reset (async assert, state held while rst=1):
  - pos=0, gray=0, wrap=0, load_err=0.
  - onehot has only the position-0 bit set: bit MOD-1 if REVERSE=1, bit 0 otherwise.
- Release: first active edge after rst deasserts evaluates inputs normally.
- Registering and latency:
  - All outputs are registered and update on the same edge.
  - Latency is 1 cycle from sampled inputs to new outputs.
  - pos, gray and onehot are always mutually consistent.
- Priority per edge: load > en > hold.
- load=1, load_val < MOD:
  - pos ← load_val; gray and onehot follow.
  - wrap=0, load_err=0; en and up are ignored.
- load=1, load_val ≥ MOD:
  - State held, load_err=1 for exactly that cycle; en ignored.
- en=1, up=1 (no load):
  - pos ← pos+1.
  - If pos==MOD-1, pos ← 0 and wrap=1 in the cycle showing the new value.
- en=1, up=0 (no load):
  - pos ← pos-1.
  - If pos==0, pos ← MOD-1 and wrap=1.
- en=0, load=0: hold; wrap=0, load_err=0.
- wrap and load_err are never high together. Both deassert on the next edge unless re-triggered.
- Continuous en with a wrap every MOD cycles produces one wrap pulse per period, not a level.
- Direction change mid-count takes effect on the same edge it is sampled; there is no extra delay.
- Gray property:
  - Successive non-wrapping counts change exactly one gray bit.
  - When MOD is not a power of 2, the wrap transition may change several bits. Example: MOD=10, 1101→0000.
- onehot is exactly one-hot at all times. The bench asserts $onehot(onehot) every cycle outside reset.
- MOD=2^W: wrap still pulses at the boundary; no load value is ever rejected.
- Reset mid-count: outputs go to reset values immediately (async); a pending wrap or load_err pulse is cleared.

Decomposition:
- Package gray_pkg:
  - Functions bin2gray(W-bit) and gray2bin(W-bit), used by the counter and the bench.
  - Typedef of the direction enum: DIR_DOWN=0, DIR_UP=1.
- Sub-module gray_onehot_decode #(MOD, REVERSE):
  - Purely combinational: gray[W-1:0] → onehot[MOD-1:0].
  - Converts internally via gray2bin.
  - Out-of-range codes yield all-zero.
- The counter registers this decoder's output. It is the generalised successor of the existing 4-bit decoder; with MOD=10, REVERSE=1 it reproduces that mapping exactly.

Test Plan:
- Reset then hold, MOD=10, REVERSE=1: rst pulse, en=0 for 3 cycles → pos=0, gray=0000, onehot=10'b10_0000_0000, wrap=0, load_err=0.
- Count up through a wrap: en=1, up=1 for 11 cycles from reset.
  - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,0000.
  - onehot walks bit 9 down to bit 0, then back to bit 9.
  - wrap=1 only on the cycle pos returns to 0.
- Count down from 0: load 0, then en=1, up=0 → pos=9, gray=1101, onehot=10'b00_0000_0001, wrap=1 for one cycle; next edge pos=8, wrap=0.
- Load priority and rejection:
  - load=1, load_val=5, en=1, up=1 → pos=5, gray=0111, no wrap.
  - Then load_val=12 → pos stays 5, load_err=1 for one cycle.
- Async reset mid-count, plus a second configuration:
  - Assert rst between edges at pos=7 → outputs go to reset values before the next edge.
  - Repeat the up-count sweep with MOD=16, REVERSE=0: onehot[k] tracks pos, and wrap fires at 15→0.
  - Check the Gray single-bit-change property on every non-wrap step.

Source files
------------

// File: rtl/gray_onehot_counter_pkg.sv
// Shared types and Gray-code helpers for the Gray/one-hot position counter.
// The helpers work on a fixed maximum width; callers zero-extend their
// W-bit values in and truncate the result back to W bits.
package gray_pkg;

  localparam int GRAY_W = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_onehot_counter_if.sv
// Control and status bundle of the Gray/one-hot position counter.
// The master drives the count controls; the slave (the counter) drives
// the registered position views and the status pulses.
interface gray_onehot_counter_if #(
  parameter int MOD = 10
);
  localparam int W = $clog2(MOD);

  logic           en;
  logic           up;
  logic           load;
  logic [W-1:0]   load_val;
  logic [W-1:0]   pos;
  logic [W-1:0]   gray;
  logic [MOD-1:0] onehot;
  logic           wrap;
  logic           load_err;

  modport master (
    output en, up, load, load_val,
    input  pos, gray, onehot, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output pos, gray, onehot, wrap, load_err
  );

endinterface

// File: rtl/gray_onehot_counter_decode.sv
// Combinational Gray -> one-hot position decoder for a modulo-MOD sequence.
// With MOD=10, REVERSE=1 it matches the legacy 4-bit Gray to 10-line decoder.
// Codes whose binary value is MOD or above produce an all-zero vector.
module gray_onehot_decode
  import gray_pkg::*;
#(
  parameter int MOD     = 10,
  parameter bit REVERSE = 1'b1
) (
  input  logic [$clog2(MOD)-1:0] gray,
  output logic [MOD-1:0]         onehot
);
  localparam int W = $clog2(MOD);

  logic [W-1:0] bin;

  assign bin = W'(gray2bin(GRAY_W'(gray)));

  // Drive the line of the decoded position; no line matches an out-of-range code.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < MOD; k++) begin
      if ({1'b0, bin} == (W+1)'(k)) begin
        onehot[REVERSE ? (MOD - 1 - k) : k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_onehot_counter.sv
// Registered, loadable up/down modulo-MOD counter presenting its position
// as binary, reflected Gray and one-hot, with wrap and rejected-load pulses.
// The one-hot view is produced by decoding the next Gray code, so all three
// views are registered from the same next-state value and always agree.
module gray_onehot_counter
  import gray_pkg::*;
#(
  parameter int MOD     = 10,
  parameter bit REVERSE = 1'b1
) (
  input logic                clk,
  input logic                rst,
  gray_onehot_counter_if.slave bus
);
  localparam int             W          = $clog2(MOD);
  localparam logic [W-1:0]   MAX_POS    = W'(MOD - 1);
  localparam logic [W:0]     MOD_W      = (W+1)'(MOD);
  localparam logic [MOD-1:0] ONEHOT_RST = REVERSE ? (MOD'(1) << (MOD - 1)) : MOD'(1);

  dir_e           dir;
  logic [W-1:0]   pos_q, next_pos;
  logic [W-1:0]   gray_q, next_gray;
  logic [MOD-1:0] onehot_q, next_onehot;
  logic           wrap_q, next_wrap;
  logic           err_q, next_err;

  assign dir = dir_e'(bus.up);

  // Next position and status pulses; load beats count, count beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_pos  = pos_q;
    next_wrap = 1'b0;
    next_err  = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_W) begin
        next_pos = bus.load_val;
      end else begin
        next_err = 1'b1;
      end
    end else if (bus.en) begin
      if (dir == DIR_UP) begin
        if (pos_q == MAX_POS) begin
          next_pos  = '0;
          next_wrap = 1'b1;
        end else begin
          next_pos = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          next_pos  = MAX_POS;
          next_wrap = 1'b1;
        end else begin
          next_pos = pos_q - 1'b1;
        end
      end
    end
  end

  assign next_gray = W'(bin2gray(GRAY_W'(next_pos)));

  gray_onehot_decode #(
    .MOD     (MOD),
    .REVERSE (REVERSE)
  ) u_decode (
    .gray   (next_gray),
    .onehot (next_onehot)
  );

  // Register all views and pulses together; reset returns to position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q    <= '0;
      gray_q   <= '0;
      onehot_q <= ONEHOT_RST;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pos_q    <= next_pos;
      gray_q   <= next_gray;
      onehot_q <= next_onehot;
      wrap_q   <= next_wrap;
      err_q    <= next_err;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.gray     = gray_q;
  assign bus.onehot   = onehot_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_gray_onehot_counter.sv
// Self-checking bench for gray_onehot_counter: a MOD=10/REVERSE=1 instance
// driven from a vector table plus hand-written reset corners, and a second
// instance with MOD=16/REVERSE=0 swept through a full up-count.
module tb_gray_onehot_counter;
  import gray_pkg::*;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  gray_onehot_counter_if #(.MOD(10)) if_a ();
  gray_onehot_counter_if #(.MOD(16)) if_b ();

  gray_onehot_counter #(.MOD(10), .REVERSE(1'b1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a)
  );

  gray_onehot_counter #(.MOD(16), .REVERSE(1'b0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  pos;
    logic [3:0]  gray;
    logic [15:0] onehot;
    logic        wrap;
    logic        err;
  } exp_t;

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic [3:0] pos;
    logic [3:0] gray;
    logic       wrap;
    logic       err;
  } vec_t;

  exp_t sb_q[$];
  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pop the oldest expected record and compare it to the observed outputs.
  task automatic check_out(input string tag, input logic [3:0] pos, input logic [3:0] gray,
                           input logic [15:0] onehot, input logic wrap, input logic err);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".pos"},      32'(pos),    32'(e.pos));
      check({tag, ".gray"},     32'(gray),   32'(e.gray));
      check({tag, ".onehot"},   32'(onehot), 32'(e.onehot));
      check({tag, ".wrap"},     32'(wrap),   32'(e.wrap));
      check({tag, ".load_err"}, 32'(err),    32'(e.err));
    end
  endtask

  function automatic logic [15:0] oh_a(input logic [3:0] p);
    return 16'h0200 >> p;
  endfunction

  function automatic logic [3:0] gray_a(input logic [3:0] p);
    logic [3:0] lut [10];
    lut = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
            4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
    return lut[p];
  endfunction

  task automatic add(input logic load, input logic [3:0] lv, input logic en, input logic up,
                     input logic [3:0] pos, input logic [3:0] gray, input logic wrap, input logic err);
    vec_t v;
    v.load = load; v.load_val = lv; v.en = en; v.up = up;
    v.pos = pos; v.gray = gray; v.wrap = wrap; v.err = err;
    tab.push_back(v);
  endtask

  // One edge on instance A with an expected result pushed at drive time.
  task automatic step_a(input string tag, input logic load, input logic [3:0] lv, input logic en,
                        input logic up, input logic [3:0] pos, input logic wrap, input logic err);
    exp_t e;
    if_a.load = load; if_a.load_val = lv; if_a.en = en; if_a.up = up;
    e.pos = pos; e.gray = gray_a(pos); e.onehot = oh_a(pos); e.wrap = wrap; e.err = err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    check_out(tag, if_a.pos, if_a.gray, 16'(if_a.onehot), if_a.wrap, if_a.load_err);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, ".pos"},      32'(if_a.pos),      32'd0);
    check({tag, ".gray"},     32'(if_a.gray),     32'd0);
    check({tag, ".onehot"},   32'(if_a.onehot),   32'h200);
    check({tag, ".wrap"},     32'(if_a.wrap),     32'd0);
    check({tag, ".load_err"}, 32'(if_a.load_err), 32'd0);
  endtask

  // One-hot invariant on both instances every cycle outside reset.
  always @(negedge clk) begin
    if (!rst_a) begin
      n_cmp++;
      assert ($onehot(if_a.onehot)) else begin
        n_bad++;
        $display("FAIL onehot_a: got %0h, expected exactly one bit", if_a.onehot);
      end
    end
    if (!rst_b) begin
      n_cmp++;
      assert ($onehot(if_b.onehot)) else begin
        n_bad++;
        $display("FAIL onehot_b: got %0h, expected exactly one bit", if_b.onehot);
      end
    end
  end

  initial begin
    exp_t       e;
    logic [3:0] prev_gray;
    logic [3:0] p;

    if_a.en = 1'b0; if_a.up = 1'b0; if_a.load = 1'b0; if_a.load_val = '0;
    if_b.en = 1'b0; if_b.up = 1'b0; if_b.load = 1'b0; if_b.load_val = '0;

    // Vector table for MOD=10, REVERSE=1.
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'd0, 4'b0000, 0, 0);
    add(0, 0, 1, 1, 4'd1, 4'b0001, 0, 0);
    add(0, 0, 1, 1, 4'd2, 4'b0011, 0, 0);
    add(0, 0, 1, 1, 4'd3, 4'b0010, 0, 0);
    add(0, 0, 1, 1, 4'd4, 4'b0110, 0, 0);
    add(0, 0, 1, 1, 4'd5, 4'b0111, 0, 0);
    add(0, 0, 1, 1, 4'd6, 4'b0101, 0, 0);
    add(0, 0, 1, 1, 4'd7, 4'b0100, 0, 0);
    add(0, 0, 1, 1, 4'd8, 4'b1100, 0, 0);
    add(0, 0, 1, 1, 4'd9, 4'b1101, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'b0000, 1, 0);
    add(0, 0, 1, 1, 4'd1, 4'b0001, 0, 0);
    add(1, 0, 1, 0, 4'd0, 4'b0000, 0, 0);
    add(0, 0, 1, 0, 4'd9, 4'b1101, 1, 0);
    add(0, 0, 1, 0, 4'd8, 4'b1100, 0, 0);
    add(1, 5, 1, 1, 4'd5, 4'b0111, 0, 0);
    add(1, 12, 1, 1, 4'd5, 4'b0111, 0, 1);
    add(0, 0, 0, 0, 4'd5, 4'b0111, 0, 0);
    add(1, 15, 1, 0, 4'd5, 4'b0111, 0, 1);
    add(0, 0, 1, 1, 4'd6, 4'b0101, 0, 0);
    add(0, 0, 1, 0, 4'd5, 4'b0111, 0, 0);
    add(1, 9, 1, 0, 4'd9, 4'b1101, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'b0000, 1, 0);
    add(0, 0, 1, 1, 4'd1, 4'b0001, 0, 0);

    // Reset state of instance A, held over edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("a_reset");
    rst_a = 1'b0;
    prev_gray = 4'b0000;

    foreach (tab[i]) begin
      if_a.load = tab[i].load; if_a.load_val = tab[i].load_val;
      if_a.en = tab[i].en; if_a.up = tab[i].up;
      e.pos = tab[i].pos; e.gray = tab[i].gray; e.onehot = oh_a(tab[i].pos);
      e.wrap = tab[i].wrap; e.err = tab[i].err;
      sb_q.push_back(e);
      @(posedge clk); #1;
      check_out($sformatf("a_vec%0d", i), if_a.pos, if_a.gray, 16'(if_a.onehot),
                if_a.wrap, if_a.load_err);
      if (tab[i].en && !tab[i].load && !tab[i].wrap)
        check($sformatf("a_vec%0d.gray_step", i), 32'($countones(if_a.gray ^ prev_gray)), 32'd1);
      prev_gray = if_a.gray;
    end

    // Async reset between edges at position 7.
    step_a("a_load7", 1, 4'd7, 0, 0, 4'd7, 0, 0);
    if_a.load = 1'b0;
    #3 rst_a = 1'b1;
    #1 check_reset_a("a_async_rst");
    @(posedge clk); #1;
    check_reset_a("a_rst_held");
    rst_a = 1'b0;

    // A pending load_err pulse is cleared by reset.
    step_a("a_bad_load", 1, 4'd12, 0, 0, 4'd0, 0, 1);
    if_a.load = 1'b0;
    #3 rst_a = 1'b1;
    #1 check_reset_a("a_rst_err");
    @(posedge clk); #1;
    rst_a = 1'b0;

    // A pending wrap pulse is cleared by reset.
    step_a("a_load9", 1, 4'd9, 0, 0, 4'd9, 0, 0);
    step_a("a_wrap", 0, 4'd0, 1, 1, 4'd0, 1, 0);
    if_a.en = 1'b0;
    #3 rst_a = 1'b1;
    #1 check_reset_a("a_rst_wrap");
    @(posedge clk); #1;
    rst_a = 1'b0;

    // Instance B: MOD=16, REVERSE=0.
    check("b_reset.pos",    32'(if_b.pos),    32'd0);
    check("b_reset.onehot", 32'(if_b.onehot), 32'h1);
    rst_b = 1'b0;
    prev_gray = 4'b0000;
    for (int i = 0; i < 17; i++) begin
      p = 4'((i + 1) % 16);
      if_b.en = 1'b1; if_b.up = 1'b1;
      e.pos = p; e.gray = p ^ (p >> 1); e.onehot = 16'(1) << p;
      e.wrap = (p == 4'd0); e.err = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      check_out($sformatf("b_up%0d", i), if_b.pos, if_b.gray, if_b.onehot, if_b.wrap, if_b.load_err);
      if (p != 4'd0)
        check($sformatf("b_up%0d.gray_step", i), 32'($countones(if_b.gray ^ prev_gray)), 32'd1);
      prev_gray = if_b.gray;
    end

    // Largest code is a legal load when MOD is a power of two.
    if_b.load = 1'b1; if_b.load_val = 4'd15; if_b.en = 1'b0;
    e.pos = 4'd15; e.gray = 4'b1000; e.onehot = 16'h8000; e.wrap = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    check_out("b_load15", if_b.pos, if_b.gray, if_b.onehot, if_b.wrap, if_b.load_err);
    if_b.load = 1'b0; if_b.en = 1'b1; if_b.up = 1'b1;
    e.pos = 4'd0; e.gray = 4'b0000; e.onehot = 16'h0001; e.wrap = 1'b1; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    check_out("b_wrap15", if_b.pos, if_b.gray, if_b.onehot, if_b.wrap, if_b.load_err);
    if_b.en = 1'b0;

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
